cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Two-master arbiter between the instruction cache and the data cache on one side and the single cache-bus (cbus) port to the memory interconnect on the other. It sits directly downstream of DCache: DCache's `creq`/`cresp` pair connects to this block's data-side port. Ownership is locked for a whole burst, from grant until the beat with `last`. A streak counter bounds how long one master can hold the bus while the other waits.

## Interface
Parameters:
- `MAX_STREAK`, default 4: maximum consecutive grants to one master while the other is waiting (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `icreq`  in  cbus_req_t  request from the instruction cache.
- `icresp`  out  cbus_resp_t  response to the instruction cache.
- `dcreq`  in  cbus_req_t  request from DCache (its `creq`).
- `dcresp`  out  cbus_resp_t  response to DCache (its `cresp`).
- `oreq`  out  cbus_req_t  request to the memory interconnect.
- `oresp`  in  cbus_resp_t  response from the memory interconnect.

## Operation
Registers:
- `state`: IDLE or BUSY.
- `owner`: I or D.
- `last_owner`: I or D; reset value D.
- `streak`: saturating at `MAX_STREAK`, width $clog2(MAX_STREAK+1).

IDLE:
- `oreq = '0`; `icresp = '0`; `dcresp = '0`.
- Grant rule, evaluated each cycle:
  - Only one `valid` high: grant that master.
  - Both high: grant I if `last_owner==D && streak>=MAX_STREAK`; otherwise grant D.
  - D therefore has priority, and I is guaranteed a grant after at most `MAX_STREAK` consecutive D grants.
- On a grant: `state<=BUSY`, `owner<=winner`.
  - `streak<=` (winner==last_owner) ? sat(streak+1) : 1.
  - `last_owner<=winner`.
- Every grant counts toward `streak`, contended or not.

BUSY:
- `oreq` = owner's request, combinational pass-through, all fields.
- Owner's resp = `oresp`. Non-owner's resp = `'0`, so its `ready` stays 0.
- Exit on `oresp.ready && oresp.last`: `state<=IDLE`. `owner` is retained but unused.
- Ownership is held until `last` even if the owner drops `valid` mid-burst (protocol violation). `oreq.valid` follows the owner's `valid` in that case. The non-owner is never granted before `last`.
- Beats without `last` (`ready && !last`) pass through with no state change.

Reset:
- Asynchronous assertion at any time, including mid-burst: `state=IDLE`, `owner=D`, `last_owner=D`, `streak=0`.
- `oreq`, `icresp`, `dcresp` read all-zero immediately, since IDLE outputs are zero.
- Deassertion: arbitration resumes on the first subsequent rising edge.

## Timing
- Grant latency is one cycle. A request sampled valid in IDLE at edge N appears on `oreq` during cycle N+1.
- Return to IDLE after `last` is one cycle. A back-to-back request from either master is granted at the edge following the IDLE cycle, so there is one dead cycle minimum between bursts.
- The data/response path is purely combinational in BUSY and adds no latency. The number of beats equals the downstream burst `len` (MLEN1..MLEN16).
- Simultaneous `last` and a new request from the other master: finish to IDLE first, then grant per the rule above.
- No output is registered, so outputs change only with `state`/`owner` or with inputs.

## Test plan
- Reset: hold `resetn=0` with both requests valid → `oreq.valid=0`, `icresp.ready=0`, `dcresp.ready=0`. Release → D granted on the first edge and `oreq.addr==dcreq.addr` the next cycle.
- Single D read burst: `dcreq` {valid, addr 0x8000_0040, len MLEN4}; `oresp.ready` for 4 cycles with `last` on the 4th, data 0x11..0x44.
  - `dcresp` mirrors all 4 beats; `icresp.ready` stays 0.
  - `oreq.valid=0` in the cycle after `last`.
- Contention: both valid at once → D burst (MLEN4) completes first, then one IDLE cycle, then `oreq.addr==icreq.addr`.
  - `icresp.ready` is never 1 during the D burst.
- Starvation bound, `MAX_STREAK=4`, both masters continuously valid, single-beat bursts → grant order D,D,D,D,I,D,D,D,D,I.
- Async reset mid-burst: assert `resetn=0` after beat 2 of 4 → `oreq.valid` falls in the same cycle without waiting for a clock edge.
  - After release, `streak=0` and D has priority again.
- Owner drops `valid` after beat 1 while I is waiting → I is not granted until `oresp.last`, then granted after one IDLE cycle.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: two-master (ICache / DCache) arbiter in front of the single
// cbus port to the memory interconnect. A grant locks ownership for a full
// burst, until the beat that carries `last`. D has priority, while a streak
// counter guarantees I a grant after at most MAX_STREAK consecutive D grants.

package cbus_pkg;
    // Burst length code: number of beats minus one.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  icreq,
    output cbus_resp_t icresp,
    input  cbus_req_t  dcreq,
    output cbus_resp_t dcresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_t;
    typedef enum logic { OWN_I = 1'b0, OWN_D = 1'b1 } owner_t;

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic   grant;
    owner_t winner;

    // Pick a winner among the requests presented while the bus is idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant  = 1'b0;
        winner = OWN_D;
        if (state_q == ST_IDLE) begin
            if (icreq.valid && dcreq.valid) begin
                grant  = 1'b1;
                winner = (last_owner_q == OWN_D && streak_q >= STREAK_MAX) ? OWN_I : OWN_D;
            end else if (dcreq.valid) begin
                grant  = 1'b1;
                winner = OWN_D;
            end else if (icreq.valid) begin
                grant  = 1'b1;
                winner = OWN_I;
            end
        end
    end

    // Next-state: lock ownership on grant, release after the beat with `last`.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        streak_d     = streak_q;
        if (state_q == ST_IDLE) begin
            if (grant) begin
                state_d      = ST_BUSY;
                owner_d      = winner;
                last_owner_d = winner;
                if (winner == last_owner_q) begin
                    streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_ONE;
                end else begin
                    streak_d = STREAK_ONE;
                end
            end
        end else if (oresp.ready && oresp.last) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; reset makes all outputs zero immediately via IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_D;
            last_owner_q <= OWN_D;
            streak_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            streak_q     <= streak_d;
        end
    end

    // Combinational steering: owner sees the interconnect, the other sees zeros.
    always_comb begin
        oreq   = '0;
        icresp = '0;
        dcresp = '0;
        if (state_q == ST_BUSY) begin
            if (owner_q == OWN_D) begin
                oreq   = dcreq;
                dcresp = oresp;
            end else begin
                oreq   = icreq;
                icresp = oresp;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios followed by a
// randomized run, all compared against a burst-level reference model.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int unsigned MAX_STREAK = 4;
    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DADDR = 32'h8000_0040;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  icreq, dcreq, oreq;
    cbus_resp_t icresp, dcresp, oresp;

    always #5 clk = ~clk;

    cbus_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
        .clk    (clk),
        .resetn (resetn),
        .icreq  (icreq),
        .icresp (icresp),
        .dcreq  (dcreq),
        .dcresp (dcresp),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: is a burst in progress, who owns it, and the full
    // history of grant winners since reset (1 = D, 0 = I).
    bit m_busy;
    bit m_owner_d;
    bit grant_hist[$];

    cbus_req_t  seen_oreq;
    cbus_resp_t seen_icresp, seen_dcresp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // How many of the most recent grants in a row went to D.
    function automatic int recent_d_run();
        int n = 0;
        for (int i = grant_hist.size() - 1; i >= 0; i--) begin
            if (!grant_hist[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner_d = 1'b1;
        grant_hist.delete();
    endtask

    task automatic model_update();
        bit pick_d;
        if (!resetn) begin
            model_reset();
        end else if (m_busy) begin
            if (oresp.ready && oresp.last) m_busy = 1'b0;
        end else if (icreq.valid || dcreq.valid) begin
            if (icreq.valid && dcreq.valid)
                pick_d = !(recent_d_run() >= int'(MAX_STREAK));
            else
                pick_d = dcreq.valid;
            m_busy    = 1'b1;
            m_owner_d = pick_d;
            grant_hist.push_back(pick_d);
        end
    endtask

    // One clock: compare outputs at the falling edge, advance model at the rising edge.
    task automatic step(input string tag);
        cbus_req_t  exp_oreq;
        cbus_resp_t exp_icresp, exp_dcresp;
        @(negedge clk);
        seen_oreq   = oreq;
        seen_icresp = icresp;
        seen_dcresp = dcresp;
        exp_oreq   = '0;
        exp_icresp = '0;
        exp_dcresp = '0;
        if (resetn && m_busy) begin
            if (m_owner_d) begin
                exp_oreq   = dcreq;
                exp_dcresp = oresp;
            end else begin
                exp_oreq   = icreq;
                exp_icresp = oresp;
            end
        end
        check({tag, ".oreq"},   128'(seen_oreq),   128'(exp_oreq));
        check({tag, ".icresp"}, 128'(seen_icresp), 128'(exp_icresp));
        check({tag, ".dcresp"}, 128'(seen_dcresp), 128'(exp_dcresp));
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input cbus_len_t len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.size     = 3'd2;
        r.addr     = addr;
        r.strobe   = 4'hf;
        r.data     = addr ^ 32'h5a5a_5a5a;
        r.len      = len;
        return r;
    endfunction

    function automatic cbus_len_t pick_len();
        case ($urandom_range(0, 4))
            0:       return MLEN1;
            1:       return MLEN2;
            2:       return MLEN4;
            3:       return MLEN8;
            default: return MLEN16;
        endcase
    endfunction

    function automatic cbus_req_t rand_req();
        cbus_req_t r;
        r          = '0;
        r.valid    = ($urandom_range(0, 99) < 60);
        r.is_write = 1'($urandom_range(0, 1));
        r.size     = 3'($urandom_range(0, 7));
        r.addr     = $urandom();
        r.strobe   = 4'($urandom_range(0, 15));
        r.data     = $urandom();
        r.len      = pick_len();
        return r;
    endfunction

    task automatic do_reset();
        icreq  = '0;
        dcreq  = '0;
        oresp  = '0;
        resetn = 1'b0;
        step("reset");
        resetn = 1'b1;
    endtask

    task automatic finish_burst();
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hdead_beef};
        step("finish");
        oresp = '0;
    endtask

    initial begin
        string order;
        model_reset();
        icreq  = '0;
        dcreq  = '0;
        oresp  = '0;

        // Reset held with both masters requesting: everything stays quiet.
        resetn = 1'b0;
        icreq  = mk_req(IADDR, MLEN4);
        dcreq  = mk_req(DADDR, MLEN4);
        step("rst_hold");
        check("rst_oreq_valid",   128'(seen_oreq.valid),   128'(1'b0));
        check("rst_icresp_ready", 128'(seen_icresp.ready), 128'(1'b0));
        check("rst_dcresp_ready", 128'(seen_dcresp.ready), 128'(1'b0));
        resetn = 1'b1;
        step("rel_grant");
        step("rel_busy");
        check("rel_addr_is_d", 128'(seen_oreq.addr), 128'(DADDR));
        finish_burst();

        // Single D read burst of four beats.
        do_reset();
        dcreq = mk_req(32'h8000_0040, MLEN4);
        step("d_grant");
        for (int k = 0; k < 4; k++) begin
            oresp = '{ready: 1'b1, last: (k == 3), data: 32'(17 * (k + 1))};
            step("d_beat");
            check("d_beat_data",  128'(seen_dcresp.data),  128'(32'(17 * (k + 1))));
            check("d_beat_ready", 128'(seen_dcresp.ready), 128'(1'b1));
            check("d_ic_ready",   128'(seen_icresp.ready), 128'(1'b0));
        end
        oresp = '0;
        dcreq = '0;
        step("d_after");
        check("d_after_valid", 128'(seen_oreq.valid), 128'(1'b0));

        // Contention: D burst first, one idle cycle, then I.
        do_reset();
        icreq = mk_req(IADDR, MLEN4);
        dcreq = mk_req(DADDR, MLEN4);
        step("c_grant");
        for (int k = 0; k < 4; k++) begin
            oresp = '{ready: 1'b1, last: (k == 3), data: 32'($urandom())};
            step("c_beat");
            check("c_addr_d",   128'(seen_oreq.addr),    128'(DADDR));
            check("c_ic_ready", 128'(seen_icresp.ready), 128'(1'b0));
        end
        oresp = '0;
        dcreq = '0;
        step("c_idle");
        check("c_idle_valid", 128'(seen_oreq.valid), 128'(1'b0));
        step("c_igrant");
        check("c_addr_i", 128'(seen_oreq.addr), 128'(IADDR));
        finish_burst();
        icreq = '0;

        // Starvation bound with single-beat bursts and both masters always valid.
        do_reset();
        icreq = mk_req(IADDR, MLEN1);
        dcreq = mk_req(DADDR, MLEN1);
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
        order = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++) begin
            step("s_idle");
            step("s_busy");
            check("starve_order", 128'(seen_oreq.addr), 128'((order[k] == "D") ? DADDR : IADDR));
        end
        icreq = '0;
        dcreq = '0;
        oresp = '0;

        // Asynchronous reset mid-burst drops the request without a clock edge.
        do_reset();
        icreq = mk_req(IADDR, MLEN4);
        dcreq = mk_req(DADDR, MLEN4);
        step("ar_grant0");
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0};
        step("ar_b1");
        step("ar_b2");
        #2;
        check("ar_pre_valid", 128'(oreq.valid), 128'(1'b1));
        resetn = 1'b0;
        #1;
        check("ar_valid",    128'(oreq.valid),   128'(1'b0));
        check("ar_dc_ready", 128'(dcresp.ready), 128'(1'b0));
        model_reset();
        oresp = '0;
        step("ar_hold");
        resetn = 1'b1;
        step("ar_grant");
        step("ar_busy");
        check("ar_d_priority", 128'(seen_oreq.addr), 128'(DADDR));
        finish_burst();

        // Owner drops valid mid-burst while I waits: I only after last + idle.
        do_reset();
        icreq = mk_req(IADDR, MLEN4);
        dcreq = mk_req(DADDR, MLEN4);
        step("od_grant");
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1};
        step("od_b1");
        dcreq.valid = 1'b0;
        oresp = '0;
        step("od_gap");
        check("od_gap_valid",    128'(seen_oreq.valid),   128'(1'b0));
        check("od_gap_ic_ready", 128'(seen_icresp.ready), 128'(1'b0));
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h2};
        step("od_b2");
        check("od_b2_addr",     128'(seen_oreq.addr),    128'(DADDR));
        check("od_b2_ic_ready", 128'(seen_icresp.ready), 128'(1'b0));
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'h3};
        step("od_last");
        check("od_last_dc_ready", 128'(seen_dcresp.ready), 128'(1'b1));
        oresp = '0;
        step("od_idle");
        check("od_idle_valid", 128'(seen_oreq.valid), 128'(1'b0));
        step("od_igrant");
        check("od_addr_i", 128'(seen_oreq.addr), 128'(IADDR));
        finish_burst();
        icreq = '0;
        dcreq = '0;

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            icreq  = rand_req();
            dcreq  = rand_req();
            oresp  = '{ready: ($urandom_range(0, 99) < 50),
                       last:  ($urandom_range(0, 99) < 40),
                       data:  32'($urandom())};
            resetn = ($urandom_range(0, 199) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
